main_mul_rr_scheduler: RTL and testbench
========================================

// Module: main_mul_rr_scheduler
// PURPOSE
//  Shares one pipelined signed x unsigned multiplier between N_REQ requesters.
//  Each requester uses valid/ready. Grants are round-robin, at most one issue per cycle.
//  A tag pipeline tracks in-flight ops and returns each product with the requester id.
//  Output backpressure is applied by gating the multiplier clock-enable.
//  Sits between the localization math kernels and the shared wide multiplier.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  ID_W     2    requester id width, >= clog2(N_REQ)
//  A_W      170  operand A width, signed
//  B_W      53   operand B width, unsigned
//  P_W      170  product width (multiplier output, low P_W bits of A*B)
//  MUL_LAT  4    multiplier latency in ce-enabled clock edges (>=1)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  reset_n    in   1          async active-low reset
//  req_valid  in   N_REQ      per-requester operand valid
//  req_ready  out  N_REQ      per-requester accept; one-hot or zero
//  req_a      in   N_REQ*A_W  packed A operands, requester i at [i*A_W +: A_W]
//  req_b      in   N_REQ*B_W  packed B operands, same packing
//  res_valid  out  1          product valid
//  res_ready  in   1          consumer accepts product
//  res_id     out  ID_W       requester that issued this product
//  res_p      out  P_W        product (wired from mul_dout)
//  mul_ce     out  1          multiplier clock-enable
//  mul_din0   out  A_W        operand A to multiplier (combinational mux)
//  mul_din1   out  B_W        operand B to multiplier (combinational mux)
//  mul_dout   in   P_W        multiplier result
//  inflight   out  ID_W+4     count of valid tags in the pipeline, 0..MUL_LAT
//  idle       out  1          no valid tags and no req_valid asserted
// BEHAVIOUR
//  Reset (async assert, sync deassert):
//   - all tags invalid; rr_ptr=N_REQ-1; inflight=0.
//   - outputs: res_valid=0, req_ready=0, mul_ce=1, idle=1 while req_valid=0.
//  Stall: mul_ce = !(res_valid && !res_ready); a bubble at the output never stalls.
//  Arbitration:
//   - grant = first requester with req_valid, searching from rr_ptr+1 upward with wrap.
//   - req_ready[g] = mul_ce for the granted requester; 0 for all others.
//   - Issue = req_valid[g] && req_ready[g]; rr_ptr <= g only on issue.
//   - A requester may hold req_valid with stable operands; it is never dropped.
//   - No requester waits more than N_REQ-1 issues.
//  Datapath:
//   - mul_din0/mul_din1 = operands of requester g (don't-care when no grant).
//   - The multiplier captures operands on the first ce edge.
//  Tag pipeline:
//   - MUL_LAT stages of {v, id}, shifting only when mul_ce=1.
//   - Stage0 <= {issue, g}.
//   - res_valid = stage[MUL_LAT-1].v; res_id = its id.
//   - Result of an issue at edge t appears after exactly MUL_LAT ce-enabled edges.
//   - Full throughput: one issue and one retire per cycle.
//  Counters:
//   - inflight +1 on issue, -1 on retire (res_valid && res_ready), unchanged if both.
//   - Never exceeds MUL_LAT.
//  Boundaries:
//   - Simultaneous issue and retire is legal.
//   - When stalled, no issue occurs and all tags and operands freeze.
//   - The multiplier has no reset: stale mul_dout is masked by invalid tags.
//   - Reset mid-operation discards in-flight products; no res_valid until new issues.
//   - rr_ptr wraps from N_REQ-1 to 0.
// TESTING
//  1. Single op: req 2, a=-3, b=5, res_ready=1 -> res_valid 4 cycles later, res_p=-15, res_id=2.
//  2. All 4 valid every cycle, res_ready=1 -> grants 0,1,2,3,0,...; results in the same order, 1/cycle.
//  3. Hold res_ready=0 for 6 cycles with the pipeline full:
//     mul_ce=0, req_ready=0, res_p/res_id stable;
//     on release, 4 results drain back-to-back with no loss or duplication.
//  4. Width edges:
//     a=-2^169, b=2^53-1 -> low 170 bits of the exact product;
//     a=2^169-1, b=0 -> 0.
//  5. Reset_n pulsed low mid-stream with 3 ops in flight:
//     res_valid=0 immediately and inflight=0; first result after reset belongs to a post-reset issue.
//  6. Req 1 holds valid continuously while req 3 toggles -> req 3 granted within 1 issue of each assertion.
//     Scoreboard checks the id/product pairing for every result.

Source files
------------

// File: rtl/main_mul_rr_scheduler.sv
// Round-robin front end for one shared pipelined signed x unsigned multiplier.
// A tag pipeline beside the multiplier returns each product with its requester id.
module main_mul_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int A_W     = 170,
    parameter int B_W     = 53,
    parameter int P_W     = 170,
    parameter int MUL_LAT = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*A_W-1:0]      req_a,
    input  logic [N_REQ*B_W-1:0]      req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ID_W-1:0]           res_id,
    output logic signed [P_W-1:0]     res_p,
    output logic                      mul_ce,
    output logic signed [A_W-1:0]     mul_din0,
    output logic [B_W-1:0]            mul_din1,
    input  logic signed [P_W-1:0]     mul_dout,
    output logic [ID_W+3:0]           inflight,
    output logic                      idle
);

    logic [ID_W-1:0]    rr_ptr;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    logic               issue;
    logic               retire;
    logic [MUL_LAT-1:0] tag_vld_p;
    logic [ID_W-1:0]    tag_id_p [MUL_LAT];

    // First valid requester after ptr, with wrap; returns {found, id}.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  ptr);
        logic [ID_W:0]   pick;
        logic [ID_W-1:0] idx;
        pick = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (valid[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

    always_comb begin
        {gnt_any, gnt_id} = rr_pick(req_valid, rr_ptr);
    end

    assign res_valid = tag_vld_p[MUL_LAT-1];
    assign res_id    = tag_id_p[MUL_LAT-1];
    assign res_p     = mul_dout;
    assign mul_ce    = !(res_valid && !res_ready);
    assign issue     = gnt_any && mul_ce;
    assign retire    = res_valid && res_ready;
    assign idle      = (inflight == '0) && !(|req_valid);

    always_comb begin
        req_ready = '0;
        mul_din0  = req_a[A_W-1:0];
        mul_din1  = req_b[B_W-1:0];
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                req_ready[i] = gnt_any && mul_ce;
                mul_din0     = req_a[i*A_W +: A_W];
                mul_din1     = req_b[i*B_W +: B_W];
            end
        end
    end

    // Stage boundary: control state (tag valids, pointer, occupancy)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_p <= '0;
            rr_ptr    <= ID_W'(N_REQ - 1);
            inflight  <= '0;
        end else begin
            if (mul_ce) begin
                tag_vld_p[0] <= issue;
                for (int i = 1; i < MUL_LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
            end
            if (issue) rr_ptr <= gnt_id;
            if (issue && !retire)      inflight <= inflight + 1'b1;
            else if (!issue && retire) inflight <= inflight - 1'b1;
        end
    end

    // Stage boundary: tag ids travel with the valids; stale ids are masked by them
    always_ff @(posedge clk) begin
        if (mul_ce) begin
            tag_id_p[0] <= gnt_id;
            for (int i = 1; i < MUL_LAT; i++) tag_id_p[i] <= tag_id_p[i-1];
        end
    end

endmodule

// File: tb/tb_main_mul_rr_scheduler.sv
// Directed bench for main_mul_rr_scheduler with a behavioural external multiplier.
module tb_main_mul_rr_scheduler;
    localparam int N_REQ = 4, ID_W = 2, A_W = 170, B_W = 53, P_W = 170, MUL_LAT = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [N_REQ-1:0]     req_valid, req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic                 res_valid, res_ready;
    logic [ID_W-1:0]      res_id;
    logic [P_W-1:0]       res_p;
    logic                 mul_ce;
    logic [A_W-1:0]       mul_din0;
    logic [B_W-1:0]       mul_din1;
    logic [P_W-1:0]       mul_dout;
    logic [ID_W+3:0]      inflight;
    logic                 idle;

    logic [A_W-1:0] ta [N_REQ];
    logic [B_W-1:0] tb [N_REQ];
    logic [P_W-1:0] mstage [MUL_LAT];
    logic [ID_W-1:0] q_id [$];
    logic [P_W-1:0]  q_p [$];
    int              q_t [$];
    int errors = 0, checks = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    main_mul_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W),
                            .P_W(P_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_p(res_p), .mul_ce(mul_ce), .mul_din0(mul_din0),
        .mul_din1(mul_din1), .mul_dout(mul_dout), .inflight(inflight), .idle(idle));

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign req_a[g*A_W +: A_W] = ta[g];
        assign req_b[g*B_W +: B_W] = tb[g];
    end

    // Low P_W bits of signed A times unsigned B.
    function automatic logic [P_W-1:0] prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        logic signed [A_W+B_W:0] sa, sb, full;
        sa   = {{(B_W+1){a[A_W-1]}}, a};
        sb   = {{(A_W+1){1'b0}}, b};
        full = sa * sb;
        return full[P_W-1:0];
    endfunction

    // External multiplier: no reset, advances only on ce.
    always @(posedge clk) begin
        if (mul_ce === 1'b1) begin
            mstage[0] <= prod(mul_din0, mul_din1);
            for (int i = 1; i < MUL_LAT; i++) mstage[i] <= mstage[i-1];
        end
    end
    assign mul_dout = mstage[MUL_LAT-1];

    always @(negedge clk) begin
        if (reset_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            q_id.push_back(res_id);
            q_p.push_back(res_p);
            q_t.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_valid = '0; res_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        q_id.delete(); q_p.delete(); q_t.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        checks++; if (mul_ce !== 1'b1) begin errors++; $display("FAIL rst_mul_ce: got %b want 1", mul_ce); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
        checks++; if (inflight !== 6'd0) begin errors++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL post_rst: res_valid=%b idle=%b want 0/1", res_valid, idle); end
    endtask

    task automatic test_single();
        int lat;
        logic [P_W-1:0] exp;
        do_reset();
        ta[2] = {A_W{1'b1}} - A_W'(2);   // -3
        tb[2] = B_W'(5);
        exp   = {P_W{1'b1}} - P_W'(14);  // -15
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", idle); end
        tick(); req_valid = '0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (inflight !== 6'd1) begin errors++; $display("FAIL single_inflight: got %0d want 1", inflight); end
            end
            if (res_valid === 1'b1) begin lat = k; break; end
            tick();
        end
        checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, MUL_LAT); end
        checks++; if (res_p !== exp) begin errors++; $display("FAIL single_prod: got %h want %h", res_p, exp); end
        checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", res_id); end
        tick();
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || inflight !== 6'd0 || idle !== 1'b1) begin errors++; $display("FAIL single_done: res_valid=%b inflight=%0d idle=%b want 0/0/1", res_valid, inflight, idle); end
    endtask

    task automatic test_round_robin();
        do_reset();
        ta[0] = A_W'(11);                   tb[0] = B_W'(3);
        ta[1] = {A_W{1'b1}} - A_W'(6);      tb[1] = B_W'(1003);
        ta[2] = A_W'(1) << 100;             tb[2] = B_W'(2003);
        ta[3] = A_W'(12345);                tb[3] = {B_W{1'b1}};
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 4'(1 << (i % 4))); end
            if (i == 6) begin
                checks++; if (inflight !== 6'd4) begin errors++; $display("FAIL rr_inflight: got %0d want 4", inflight); end
            end
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 30 && q_id.size() < 8; k++) tick();
        checks++; if (q_id.size() != 8) begin errors++; $display("FAIL rr_count: got %0d want 8", q_id.size()); end
        for (int i = 0; i < 8 && i < q_id.size(); i++) begin
            checks++; if (q_id[i] !== ID_W'(i % 4) || q_p[i] !== prod(ta[i % 4], tb[i % 4]))
                begin errors++; $display("FAIL rr_result%0d: got id %0d p %h want id %0d p %h", i, q_id[i], q_p[i], i % 4, prod(ta[i % 4], tb[i % 4])); end
            checks++; if (q_t[i] != q_t[0] + i) begin errors++; $display("FAIL rr_spacing%0d: got cycle %0d want %0d", i, q_t[i], q_t[0] + i); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 4'(1 << i)) begin errors++; $display("FAIL bp_grant%0d: got %b want %b", i, req_ready, 4'(1 << i)); end
            tick();
        end
        res_ready = 1'b0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            checks++; if (mul_ce !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall%0d: mul_ce=%b req_ready=%b want 0/0000", s, mul_ce, req_ready); end
            checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_p !== prod(ta[0], tb[0])) begin errors++; $display("FAIL bp_hold%0d: valid=%b id=%0d p=%h want 1/0/%h", s, res_valid, res_id, res_p, prod(ta[0], tb[0])); end
            checks++; if (inflight !== 6'd4) begin errors++; $display("FAIL bp_inflight%0d: got %0d want 4", s, inflight); end
            tick();
        end
        res_ready = 1'b1; req_valid = '0;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            checks++; if (res_valid !== 1'b1 || res_id !== ID_W'(d)) begin errors++; $display("FAIL bp_drain%0d: valid=%b id=%0d want 1/%0d", d, res_valid, res_id, d); end
            tick();
        end
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || inflight !== 6'd0) begin errors++; $display("FAIL bp_empty: valid=%b inflight=%0d want 0/0", res_valid, inflight); end
        checks++; if (q_id.size() != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", q_id.size()); end
        for (int i = 0; i < 4 && i < q_id.size(); i++) begin
            checks++; if (q_id[i] !== ID_W'(i) || q_p[i] !== prod(ta[i], tb[i])) begin errors++; $display("FAIL bp_result%0d: got id %0d p %h want id %0d p %h", i, q_id[i], q_p[i], i, prod(ta[i], tb[i])); end
        end
    endtask

    task automatic test_width_edges();
        logic [P_W-1:0] exp0;
        do_reset();
        ta[0] = '0; ta[0][A_W-1] = 1'b1;    // -2^169
        tb[0] = {B_W{1'b1}};                // 2^53-1
        ta[1] = {1'b0, {(A_W-1){1'b1}}};    // 2^169-1
        tb[1] = '0;
        exp0 = '0; exp0[P_W-1] = 1'b1;      // -2^222 + 2^169 mod 2^170 = 2^169
        req_valid = 4'b0011;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL we_grant0: got %b want 0001", req_ready); end
        tick(); req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL we_grant1: got %b want 0010", req_ready); end
        tick(); req_valid = '0;
        for (int k = 0; k < 20 && q_id.size() < 2; k++) tick();
        checks++; if (q_id.size() != 2) begin errors++; $display("FAIL we_count: got %0d want 2", q_id.size()); end
        if (q_id.size() >= 2) begin
            checks++; if (q_id[0] !== 2'd0 || q_p[0] !== exp0) begin errors++; $display("FAIL we_minneg: got id %0d p %h want id 0 p %h", q_id[0], q_p[0], exp0); end
            checks++; if (q_id[1] !== 2'd1 || q_p[1] !== '0) begin errors++; $display("FAIL we_zero: got id %0d p %h want id 1 p 0", q_id[1], q_p[1]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b0111;
        tick(); tick(); tick();
        req_valid = '0;
        tick();
        checks++; if (res_valid !== 1'b1 || inflight !== 6'd3) begin errors++; $display("FAIL rm_before: valid=%b inflight=%0d want 1/3", res_valid, inflight); end
        reset_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", res_valid); end
        checks++; if (inflight !== 6'd0) begin errors++; $display("FAIL rm_inflight: got %0d want 0", inflight); end
        checks++; if (mul_ce !== 1'b1) begin errors++; $display("FAIL rm_ce: got %b want 1", mul_ce); end
        @(posedge clk); #1;
        reset_n = 1'b1; res_ready = 1'b1;
        q_id.delete(); q_p.delete(); q_t.delete();
        for (int k = 0; k < 8; k++) tick();
        checks++; if (q_id.size() != 0 || res_valid !== 1'b0) begin errors++; $display("FAIL rm_stale: results=%0d valid=%b want 0/0", q_id.size(), res_valid); end
        ta[3] = A_W'(77); tb[3] = B_W'(9);
        req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rm_grant: got %b want 1000", req_ready); end
        tick(); req_valid = '0;
        for (int k = 0; k < 12 && q_id.size() < 1; k++) tick();
        checks++; if (q_id.size() != 1) begin errors++; $display("FAIL rm_count: got %0d want 1", q_id.size()); end
        if (q_id.size() >= 1) begin
            checks++; if (q_id[0] !== 2'd3 || q_p[0] !== P_W'(693)) begin errors++; $display("FAIL rm_first: got id %0d p %h want id 3 p 2b5", q_id[0], q_p[0]); end
        end
    endtask

    task automatic test_fairness();
        logic [7:0] v3_pat;
        int exp_id [8];
        v3_pat = 8'h4E;
        exp_id = '{1, 3, 1, 3, 1, 1, 3, 1};
        do_reset();
        ta[1] = {A_W{1'b1}} - A_W'(999);    tb[1] = B_W'(4242);
        ta[3] = A_W'(1) << 150;             tb[3] = B_W'(1) << 40;
        for (int c = 0; c < 8; c++) begin
            req_valid = {v3_pat[c], 1'b0, 1'b1, 1'b0};
            @(negedge clk);
            checks++; if (req_ready !== 4'(1 << exp_id[c])) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", c, req_ready, 4'(1 << exp_id[c])); end
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 20 && q_id.size() < 8; k++) tick();
        checks++; if (q_id.size() != 8) begin errors++; $display("FAIL fair_count: got %0d want 8", q_id.size()); end
        for (int i = 0; i < 8 && i < q_id.size(); i++) begin
            checks++; if (q_id[i] !== ID_W'(exp_id[i]) || q_p[i] !== prod(ta[exp_id[i]], tb[exp_id[i]]))
                begin errors++; $display("FAIL fair_result%0d: got id %0d p %h want id %0d p %h", i, q_id[i], q_p[i], exp_id[i], prod(ta[exp_id[i]], tb[exp_id[i]])); end
        end
        @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL fair_idle: got %b want 1", idle); end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = '0; res_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin ta[i] = '0; tb[i] = '0; end
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_width_edges();
        test_reset_mid();
        test_fairness();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
